// File: rtl/multdiv_unit.sv
// Multicycle signed multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, sign fixed up in the DONE cycle.
module multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 mul_q, mul_d;
  logic                 neg_q, neg_d;
  logic                 dz_q, dz_d;
  // hi: product accumulator (mul) / partial remainder (div)
  // sa: shifted multiplicand (mul) / dividend shifting out, quotient shifting in (div)
  // sb: multiplier shifting right (mul) / divisor (div)
  logic [2*WIDTH-1:0]   hi_q, hi_d;
  logic [2*WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH:0]       sb_q, sb_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic                 exc_q, exc_d;
  logic                 rdy_q, rdy_d;
  logic                 busy_q, busy_d;

  logic [WIDTH:0]       a_ext, b_ext, a_mag, b_mag;
  logic [WIDTH:0]       rem_shift;
  logic [WIDTH+1:0]     diff;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH:0]       prod_top;
  logic [WIDTH-1:0]     quo;
  logic                 start;

  always_comb begin
    start     = ctrl_MULT | ctrl_DIV;
    a_ext     = {data_operandA[WIDTH-1], data_operandA};
    b_ext     = {data_operandB[WIDTH-1], data_operandB};
    a_mag     = a_ext[WIDTH] ? -a_ext : a_ext;
    b_mag     = b_ext[WIDTH] ? -b_ext : b_ext;
    rem_shift = {hi_q[WIDTH-1:0], sa_q[WIDTH-1]};
    diff      = {1'b0, rem_shift} - {1'b0, sb_q};
    prod      = neg_q ? -hi_q : hi_q;
    prod_top  = prod[2*WIDTH-1:WIDTH-1];
    quo       = neg_q ? -sa_q[WIDTH-1:0] : sa_q[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mul_d   = mul_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    exc_d   = exc_q;
    rdy_d   = 1'b0;
    busy_d  = busy_q;
    if (start) begin
      // A start always wins, including over an operation already in flight.
      state_d = S_RUN;
      cnt_d   = '0;
      busy_d  = 1'b1;
      mul_d   = ctrl_MULT;
      neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      dz_d    = (data_operandB == '0);
      hi_d    = '0;
      sa_d    = {{(WIDTH-1){1'b0}}, a_mag};
      sb_d    = b_mag;
    end else begin
      case (state_q)
        S_RUN: begin
          cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
          if (mul_q) begin
            if (sb_q[0]) hi_d = hi_q + sa_q;
            sa_d = sa_q << 1;
            sb_d = sb_q >> 1;
          end else begin
            hi_d = {{(WIDTH-1){1'b0}}, diff[WIDTH+1] ? rem_shift : diff[WIDTH:0]};
            sa_d = {sa_q[2*WIDTH-2:0], ~diff[WIDTH+1]};
          end
          if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_DONE;
        end
        S_DONE: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          rdy_d   = 1'b1;
          if (mul_q) begin
            res_d = prod[WIDTH-1:0];
            exc_d = ~((&prod_top) | ~(|prod_top));
          end else if (dz_q) begin
            res_d = '0;
            exc_d = 1'b1;
          end else begin
            // Only INT_MIN / -1 yields a positive quotient with the top bit set.
            res_d = quo;
            exc_d = ~neg_q & sa_q[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mul_q   <= 1'b0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mul_q   <= mul_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Parametrised multicycle signed multiply/divide unit.
- Successor to the single-cycle combinational ALU: the ALU keeps add/sub/logic/shift, and this block executes mul/div.
- Sits beside the ALU in the execute stage. The pipeline stalls on busy and picks up the result on data_resultRDY.
- Radix-2 iterative datapath: shift-add for multiply, restoring division for divide.

Parameters:
- WIDTH, 32, operand and result width in bits (min 4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- ctrl_MULT  in  1  single-cycle start pulse: multiply.
- ctrl_DIV  in  1  single-cycle start pulse: divide.
- data_operandA  in  WIDTH  multiplicand / dividend (two's complement).
- data_operandB  in  WIDTH  multiplier / divisor (two's complement).
- data_result  out  WIDTH  product low WIDTH bits or quotient.
- data_exception  out  1  overflow or divide-by-zero flag for data_result.
- data_resultRDY  out  1  one-cycle pulse: result/exception valid.
- busy  out  1  high while an operation is in progress.

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset). All outputs are registered.
- Reset:
  - state IDLE, counter 0.
  - data_result 0, data_exception 0, data_resultRDY 0, busy 0.
- States:
  - IDLE: wait for start.
  - RUN: WIDTH iterations, one per clock.
  - DONE: one cycle; assert data_resultRDY, then return to IDLE.
- Start:
  - At a rising edge with ctrl_MULT or ctrl_DIV high: latch operands and op, clear the counter, enter RUN, busy=1 from the next cycle.
  - Operand inputs are ignored at all other times.
- Latency:
  - Start sampled at edge E0; data_resultRDY is high for exactly the cycle after edge E0+WIDTH+1.
  - For WIDTH=32 this is 33 cycles.
  - busy is high from E0 to E0+WIDTH+1, and low in the RDY cycle.
- Result hold: data_result and data_exception hold their values after the RDY pulse until the next RDY or reset.
- Signed handling:
  - Take magnitudes of A and B, iterate unsigned, then negate the result if sign(A)^sign(B).
  - Magnitude of INT_MIN is held in WIDTH+1 bits.
- Multiply:
  - data_result = low WIDTH bits of the 2*WIDTH-bit signed product.
  - data_exception=1 when the upper WIDTH+1 product bits are not all equal (product does not fit signed WIDTH).
- Divide:
  - Quotient truncates toward zero; the remainder is discarded.
  - B==0: data_result=0, data_exception=1. Full latency still applies, for deterministic timing.
  - A==INT_MIN and B==-1: data_result=INT_MIN, data_exception=1.
- Simultaneous ctrl_MULT and ctrl_DIV: multiply wins; divide is ignored.
- Start while busy (in RUN or DONE):
  - Abort the current op with no RDY pulse for it.
  - Restart with the new operands and op at that edge; latency is counted from the new edge.
- Reset mid-operation: return to IDLE immediately; no RDY pulse; outputs take their reset values.
- Counter: saturates; it never wraps within an operation.
- No X on outputs after the first reset.

Test Plan:
- WIDTH=32, ctrl_MULT, A=7, B=-3 (FFFFFFFD):
  - RDY exactly 33 cycles after the start edge.
  - data_result=FFFFFFEB, data_exception=0.
  - busy high for the preceding 33 edges.
- ctrl_MULT, A=00010000, B=00010000: data_result=00000000, data_exception=1.
- ctrl_MULT, A=80000000, B=FFFFFFFF: data_result=80000000, data_exception=1.
- ctrl_DIV checks:
  - A=FFFFFFF9 (-7), B=2: data_result=FFFFFFFD (-3), exc 0.
  - A=5, B=0: data_result=0, exc 1, after 33 cycles.
  - A=80000000, B=FFFFFFFF: data_result=80000000, exc 1.
- Abort/restart:
  - ctrl_MULT (6×7), then ctrl_DIV (100/7) 10 cycles later.
  - Exactly one RDY, 33 cycles after the DIV edge, with data_result=0000000E.
  - No RDY for the multiply.
- Reset and hold:
  - ctrl_MULT and ctrl_DIV together (A=3, B=4) give data_result=0000000C.
  - Then start a new op and assert reset at cycle 15: no RDY, all outputs 0, busy=0 the next cycle.
  - A subsequent op completes normally.
